// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the vertical phase type.
// Imported by the horizontal counter and by vert_timing.
package vga_timing_pkg;

  localparam int unsigned H_LAST   = 799;
  localparam int unsigned H_START  = 144;
  localparam int unsigned H_ACTIVE = 640;

  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;

  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_FP_START  = V_ACT_START + V_ACTIVE;

  localparam int unsigned HW  = 10;
  localparam int unsigned VW  = 10;
  localparam int unsigned PYW = 9;
  localparam int unsigned FCW = 16;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BP     = 2'd1,
    ACTIVE = 2'd2,
    FP     = 2'd3
  } phase_t;

endpackage

// File: rtl/vert_timing.sv
// Vertical timing stage: line counter, phase FSM and a 1-cycle aligned output stage.
// Optional frame counter enabled by VERT_TIMING_FRAME_COUNT_EN.
module vert_timing
  import vga_timing_pkg::*;
(
  input  logic           clk25M,
  input  logic           reset,
  input  logic [HW-1:0]  hcount,
  input  logic           hterm,
  input  logic           hs_in,
  output logic [VW-1:0]  vcount,
  output logic           hs_out,
  output logic           VS,
  output logic           video_on,
  output logic [HW-1:0]  pixel_x,
  output logic [PYW-1:0] pixel_y,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  phase_t         phase, phase_nxt;
  logic [VW-1:0]  vcount_nxt;
  logic           h_vis, vis;
  logic           vs_nxt, video_nxt, fs_nxt;
  logic [HW-1:0]  px_nxt;
  logic [PYW-1:0] py_nxt;

  // State register
  always_ff @(posedge clk25M) begin
    if (reset) begin
      vcount <= '0;
      phase  <= SYNC;
    end else begin
      vcount <= vcount_nxt;
      phase  <= phase_nxt;
    end
  end

  // Line advance and phase transitions; phase tracks the post-update vcount
  always_comb begin
    vcount_nxt = vcount;
    phase_nxt  = phase;
    if (hterm) begin
      vcount_nxt = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
    end
    case (phase)
      SYNC:    if (vcount_nxt == VW'(V_SYNC))      phase_nxt = BP;
      BP:      if (vcount_nxt == VW'(V_ACT_START)) phase_nxt = ACTIVE;
      ACTIVE:  if (vcount_nxt == VW'(V_FP_START))  phase_nxt = FP;
      FP:      if (vcount_nxt == '0)               phase_nxt = SYNC;
      default: phase_nxt = SYNC;
    endcase
  end

  // Output decode from the pre-update line state and the current pixel
  always_comb begin
    h_vis     = (hcount >= HW'(H_START)) && (hcount < HW'(H_START + H_ACTIVE));
    vis       = (phase == ACTIVE) && h_vis;
    vs_nxt    = (phase == SYNC);
    video_nxt = vis;
    px_nxt    = '0;
    py_nxt    = '0;
    if (vis) begin
      px_nxt = hcount - HW'(H_START);
      py_nxt = PYW'(vcount - VW'(V_ACT_START));
    end
    fs_nxt = hterm && (vcount == VW'(V_TOTAL - 1));
  end

  // Output register stage keeps HS, VS and video_on aligned to the pixel
  always_ff @(posedge clk25M) begin
    if (reset) begin
      hs_out      <= 1'b0;
      VS          <= 1'b0;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_out      <= hs_in;
      VS          <= vs_nxt;
      video_on    <= video_nxt;
      pixel_x     <= px_nxt;
      pixel_y     <= py_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef VERT_TIMING_FRAME_COUNT_EN
  logic [FCW-1:0] frame_cnt_q;

  always_ff @(posedge clk25M) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + FCW'(1);
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: doc/vert_timing.md
Name: vert_timing

Overview:
- Vertical timing stage, directly downstream of the horizontal pixel counter in the VGA/Pong video path.
- Consumes the horizontal count, the end-of-line terminal pulse and HS.
- Produces the line counter, VS, the phase FSM, a pixel-aligned video_on window, pixel coordinates and a frame-start pulse.
- The pixel/ball/paddle renderer uses these outputs.

Parameters:
- V_SYNC, 2, lines in vertical sync pulse
- V_BP, 33, lines in vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, lines in vertical front porch (total 525 lines)
- H_START, 144, first visible hcount (96 sync + 48 back porch)
- H_ACTIVE, 640, visible pixels per line
- H_LAST, 799, last hcount of a line

Ports:
- clk25M  in  1  25 MHz pixel clock; only clock
- reset  in  1  synchronous, active-high reset
- hcount  in  10  horizontal pixel count, 0..799
- hterm  in  1  high for exactly the cycle hcount==799
- hs_in  in  1  horizontal sync, high for hcount 0..95
- vcount  out  10  live line counter, 0..524
- hs_out  out  1  hs_in delayed 1 cycle
- VS  out  1  vertical sync, active-high during SYNC lines, delayed 1 cycle
- video_on  out  1  visible-pixel window, delayed 1 cycle
- pixel_x  out  10  hcount-H_START when visible, else 0; delayed 1 cycle
- pixel_y  out  9  vcount-(V_SYNC+V_BP) when visible, else 0; delayed 1 cycle
- frame_start  out  1  one-cycle pulse at start of each frame
- frame_count  out  16  frame counter (see Optional Feature)

Behaviour:
- All state updates on posedge clk25M. reset has priority over all other inputs.
- Reset values: vcount=0, phase=SYNC, hs_out=0, VS=0, video_on=0, pixel_x=0, pixel_y=0, frame_start=0, frame_count=0.
- Line advance: on an edge with hterm=1, vcount <= (vcount==524) ? 0 : vcount+1. Otherwise vcount holds. hcount is not checked against hterm; hterm alone advances.
- Phase FSM states, with vcount ranges:
  - SYNC: 0..1
  - BP: 2..34
  - ACTIVE: 35..514
  - FP: 515..524
  - Transitions occur on the same edge that vcount crosses a boundary.
  - Transition order: SYNC->BP->ACTIVE->FP->SYNC.
  - Phase is always a pure function of the post-update vcount. No illegal state is reachable; any unencoded state returns to SYNC on the next edge.
- Output pipeline, 1-cycle latency: hs_out, VS, video_on, pixel_x and pixel_y at cycle n+1 reflect the (hcount, pre-update vcount/phase, hs_in) sampled at edge n. This keeps HS/VS/video_on mutually aligned to the pixel.
- video_on = (phase==ACTIVE) && (H_START <= hcount < H_START+H_ACTIVE).
- Widths: pixel_x ranges 0..639; pixel_y ranges 0..479. The subtractions are computed at 10 bits; pixel_y is truncated to 9 bits.
- frame_start: registered. High for exactly one cycle, the first cycle vcount==0 after a 524->0 wrap. It is not asserted on release from reset.
- hterm held high for several cycles (illegal): vcount advances once per high cycle; no protection.
- Reset mid-line or mid-frame: the next cycle restarts at vcount=0 in SYNC with all outputs at their reset values.

Optional Feature:
- Macro: VERT_TIMING_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 (mod 2^16) on every cycle frame_start is high, and clears on reset. It is used by the game logic for ball-speed timing.
- Undefined: the frame_count port remains present, tied to 16'd0; no counter register is synthesized.

Decomposition:
- Shared package vga_timing_pkg holds:
  - H_LAST, H_START, H_ACTIVE, V_SYNC, V_BP, V_ACTIVE, V_FP
  - derived V_TOTAL=525 and V_ACT_START=35
  - the phase enum: SYNC, BP, ACTIVE, FP, 2-bit encoding
- The horizontal counter also imports this package.
- No sub-module: the counter, FSM and output register stage are implemented in one module.

Test Plan:
- Reset then run 800 cycles with hterm pulsed at hcount==799 -> vcount goes 0->1 on that edge; VS=1 throughout line 0; frame_start stays 0.
- Drive lines up to vcount=35, hcount=144 -> one cycle later video_on=1, pixel_x=0, pixel_y=0. At hcount=783, pixel_x=639. At hcount=784, video_on=0 the following cycle.
- Run a full frame of 525*800 cycles -> vcount wraps 524->0; frame_start is high for exactly one cycle (the first vcount==0 cycle); VS is high for exactly 1600 pixel cycles per frame.
- At vcount=514, hcount=200 -> pixel_y=479. At vcount=515 -> phase FP and video_on stays 0 for the whole line.
- Assert reset at vcount=300, hcount=400 for one cycle -> the next cycle has vcount=0, VS=0, video_on=0; the frame restarts cleanly and VS asserts one cycle later.
- With VERT_TIMING_FRAME_COUNT_EN defined, run 3 frames -> frame_count=3. Undefined -> frame_count=0 throughout.
